mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: AW, 32, address width in bits.
REQ-002 SHALL have parameter: DW, 32, data width in bits.
REQ-003 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  in  1  synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port: f_req  in  1  fetch requester read request; held until granted.
REQ-006 SHALL have port: f_addr  in  AW  fetch address; stable while f_req high.
REQ-007 SHALL have port: f_gnt  out  1  fetch request accepted this cycle.
REQ-008 SHALL have port: f_rvalid  out  1  fetch read data valid.
REQ-009 SHALL have port: f_rdata  out  DW  fetch read data.
REQ-010 SHALL have port: d_req  in  1  data requester request; held until granted.
REQ-011 SHALL have port: d_we  in  1  data request is a write when 1, a read when 0.
REQ-012 SHALL have port: d_addr  in  AW  data address.
REQ-013 SHALL have port: d_wdata  in  DW  data write value.
REQ-014 SHALL have port: d_gnt  out  1  data request accepted this cycle.
REQ-015 SHALL have port: d_rvalid  out  1  data read data valid.
REQ-016 SHALL have port: d_rdata  out  DW  data read data.
REQ-017 SHALL have ports m_en/m_we (out 1), m_addr (out AW), m_wdata (out DW) and m_rdata (in DW), forming the single shared synchronous memory port; m_rdata is valid exactly one cycle after m_en=1 with m_we=0.

Function
REQ-018 SHALL grant at most one requester per cycle; f_gnt and d_gnt are never both 1.
REQ-019 SHALL drive grants combinationally from current requests and the arbitration state; a grant completes the handshake in that cycle.
REQ-020 SHALL drive m_en=1 and route the winner's addr/we/wdata to the memory port in the grant cycle; the fetch side always presents m_we=0. With no grant, m_en=0 and m_we=0.
REQ-021 SHALL record the response owner (NONE/FETCH/DATA) in a registered state; a granted read sets FETCH or DATA, and a granted write or no grant sets NONE.
REQ-022 SHALL assert f_rvalid or d_rvalid for exactly one cycle, in the cycle after a granted read to that requester, with the matching rdata output equal to m_rdata.
REQ-023 SHALL hold both rdata outputs at 0 whenever the corresponding rvalid is 0.
REQ-024 SHALL accept a new grant in the same cycle a previous read's response is returned, sustaining one access per cycle.
REQ-025 SHALL, in fixed-priority mode, grant d_req over f_req when both are requested.
REQ-026 SHALL produce no response for a write; a write is complete at its grant.

Reset
REQ-027 SHALL, while rst_n=0, force f_gnt, d_gnt, m_en, m_we, f_rvalid and d_rvalid to 0 and set the response owner to NONE.
REQ-028 SHALL discard any read in flight when reset is asserted; no rvalid follows it.
REQ-029 SHALL set the round-robin last-winner register to FETCH on reset, so the first contested grant goes to DATA.

Configuration
REQ-030 SHALL, when MEM_ARBITER_RR_EN is defined, use round-robin arbitration: on contention the requester not granted most recently wins, and last-winner updates on every grant.
REQ-031 SHALL, when MEM_ARBITER_RR_EN is undefined, use fixed priority per REQ-025 and contain no last-winner register.

Structure
REQ-032 SHALL take the response-owner enum (OWN_NONE, OWN_FETCH, OWN_DATA) from the shared package furv_pkg, which also holds the default widths.
REQ-033 SHALL place the grant decision in one sub-module, mem_arbiter_pick, which is combinational: inputs are the requests and last-winner, outputs are the grants.

Verification
REQ-034 SHALL cover: f_req=1 with f_addr=0x10, memory holding 0x13 there -> f_gnt in cycle 0, m_addr=0x10, f_rvalid=1 with f_rdata=0x13 in cycle 1.
REQ-035 SHALL cover: f_req and d_req (read 0x200) both held for 4 cycles -> fixed mode gives d_gnt every cycle; RR mode alternates D,F,D,F.
REQ-036 SHALL cover: d_req with d_we=1, addr 0x40, wdata 0xDEADBEEF, then a data read of 0x40 -> m_we=1 in the grant cycle, no d_rvalid for the write, then d_rdata=0xDEADBEEF.
REQ-037 SHALL cover: back-to-back fetch reads of 0x0, 0x4 and 0x8 -> three consecutive grants and three consecutive f_rvalid cycles with matching data.
REQ-038 SHALL cover: rst_n=0 in the cycle after a granted read -> no rvalid, all outputs 0, and the first contested grant after reset goes to DATA.
REQ-039 SHALL cover: no requests for 3 cycles -> m_en=0, both gnt=0 and both rvalid=0 throughout.

Source files
------------

// File: rtl/furv_pkg.sv
// rtl/furv_pkg.sv - shared widths and arbitration enums for the furv memory path
package furv_pkg;

    localparam int FURV_AW = 32;
    localparam int FURV_DW = 32;

    // Which requester owns the read response arriving next cycle.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } own_e;

    // Requester granted most recently (round-robin history).
    typedef enum logic {
        WIN_FETCH = 1'b0,
        WIN_DATA  = 1'b1
    } win_e;

endpackage

// File: rtl/mem_arbiter_pick.sv
// rtl/mem_arbiter_pick.sv - combinational grant decision between fetch and data requesters
//
// Ports:
//   f_req, d_req   in   requests (already qualified by reset in the parent)
//   last_win       in   requester granted most recently
//   f_gnt, d_gnt   out  one-hot-or-zero grants
//
// On contention the requester that did not win last time is granted. Tying
// last_win to WIN_FETCH turns this into fixed data-over-fetch priority.
module mem_arbiter_pick
    import furv_pkg::*;
(
    input  logic f_req,
    input  logic d_req,
    input  win_e last_win,
    output logic f_gnt,
    output logic d_gnt
);

    assign d_gnt = d_req & (~f_req | (last_win == WIN_FETCH));
    assign f_gnt = f_req & ~d_gnt;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter onto one synchronous memory port
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   f_req/f_addr -> f_gnt/f_rvalid/f_rdata
//                                       fetch requester (read only)
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata
//                                       data requester (read or write)
//   m_en/m_we/m_addr/m_wdata, m_rdata   shared memory port, 1-cycle read latency
//
// Build option: define MEM_ARBITER_RR_EN for round-robin arbitration;
// otherwise data has fixed priority over fetch.
module mem_arbiter
    import furv_pkg::*;
#(
    parameter int AW = FURV_AW,
    parameter int DW = FURV_DW
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    win_e last_win;
    own_e owner;
    own_e owner_next;

    // Gating requests with rst_n keeps every grant-derived output low in reset.
    logic f_req_q;
    logic d_req_q;
    assign f_req_q = f_req & rst_n;
    assign d_req_q = d_req & rst_n;

    mem_arbiter_pick u_pick (
        .f_req    (f_req_q),
        .d_req    (d_req_q),
        .last_win (last_win),
        .f_gnt    (f_gnt),
        .d_gnt    (d_gnt)
    );

`ifdef MEM_ARBITER_RR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_win <= WIN_FETCH;
        end else if (d_gnt) begin
            last_win <= WIN_DATA;
        end else if (f_gnt) begin
            last_win <= WIN_FETCH;
        end
    end
`else
    // Constant history makes the pick module resolve ties to data.
    assign last_win = WIN_FETCH;
`endif

    always_comb begin
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (d_gnt) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (f_gnt) begin
            m_en    = 1'b1;
            m_addr  = f_addr;
        end
    end

    always_comb begin
        owner_next = OWN_NONE;
        if (d_gnt && !d_we) begin
            owner_next = OWN_DATA;
        end else if (f_gnt) begin
            owner_next = OWN_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_next;
        end
    end

    // Qualifying with rst_n drops a response whose read was granted just
    // before reset asserted.
    assign f_rvalid = rst_n & (owner == OWN_FETCH);
    assign d_rvalid = rst_n & (owner == OWN_DATA);
    assign f_rdata  = f_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a reference model
module tb_mem_arbiter;
    import furv_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MEM_ARBITER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt, f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        if (a == 32'h10) return 32'h13;
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Memory device attached to the shared port.
    logic [DW-1:0] dev_mem [logic [AW-1:0]];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) dev_mem[m_addr] = m_wdata;
            else m_rdata <= dev_mem.exists(m_addr) ? dev_mem[m_addr] : mem_init(m_addr);
        end
    end

    // Observed outputs; address/wdata only meaningful while the port is used.
    typedef struct packed {
        logic          f_gnt, d_gnt, m_en, m_we, f_rvalid, d_rvalid;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata, f_rdata, d_rdata;
    } obs_t;

    obs_t obs;
    always_comb begin
        obs          = '0;
        obs.f_gnt    = f_gnt;
        obs.d_gnt    = d_gnt;
        obs.m_en     = m_en;
        obs.m_we     = m_we;
        obs.f_rvalid = f_rvalid;
        obs.d_rvalid = d_rvalid;
        obs.m_addr   = m_en ? m_addr : '0;
        obs.m_wdata  = (m_en && m_we) ? m_wdata : '0;
        obs.f_rdata  = f_rdata;
        obs.d_rdata  = d_rdata;
    end

    // Reference model: queue of responses owed, memory contents, last winner.
    typedef struct {
        bit            is_data;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          rsp_q[$];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    bit            last_was_data = 1'b0;
    obs_t          exp_o;

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    task automatic model_expect();
        bit pick_d;
        exp_o = '0;
        if (rst_n) begin
            pick_d = d_req && (!f_req || !RR || !last_was_data);
            exp_o.d_gnt = pick_d;
            exp_o.f_gnt = f_req && !pick_d;
            exp_o.m_en  = exp_o.d_gnt || exp_o.f_gnt;
            if (exp_o.d_gnt) begin
                exp_o.m_we   = d_we;
                exp_o.m_addr = d_addr;
                if (d_we) exp_o.m_wdata = d_wdata;
            end else if (exp_o.f_gnt) begin
                exp_o.m_addr = f_addr;
            end
            if (rsp_q.size() > 0) begin
                if (rsp_q[0].is_data) begin
                    exp_o.d_rvalid = 1'b1;
                    exp_o.d_rdata  = rsp_q[0].data;
                end else begin
                    exp_o.f_rvalid = 1'b1;
                    exp_o.f_rdata  = rsp_q[0].data;
                end
            end
        end
    endtask

    task automatic model_advance();
        rsp_t r;
        if (!rst_n) begin
            rsp_q.delete();
            last_was_data = 1'b0;
        end else begin
            if (rsp_q.size() > 0) void'(rsp_q.pop_front());
            if (exp_o.d_gnt && d_we) begin
                ref_mem[d_addr] = d_wdata;
            end else if (exp_o.m_en) begin
                r.is_data = exp_o.d_gnt;
                r.data    = ref_read(exp_o.m_addr);
                rsp_q.push_back(r);
            end
            if (exp_o.m_en) last_was_data = exp_o.d_gnt;
        end
    endtask

    task automatic set_in(input bit rn, input bit fr, input logic [AW-1:0] fa,
                          input bit dr, input bit dwe, input logic [AW-1:0] da,
                          input logic [DW-1:0] dwd);
        rst_n = rn; f_req = fr; f_addr = fa;
        d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        @(negedge clk);
        model_expect();
    endtask

    task automatic adv();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom);
            checks++;
            if (obs !== '0) begin
                errors++;
                $display("FAIL reset c%0d: got %h want 0", i, obs);
            end
            adv();
        end
    endtask

    task automatic test_fetch_read();
        set_in(1, 1, 32'h10, 0, 0, 0, 0);
        checks++;
        if (!(f_gnt === 1'b1 && d_gnt === 1'b0 && m_en === 1'b1 && m_we === 1'b0 && m_addr === 32'h10)) begin
            errors++;
            $display("FAIL fetch_read grant: got f_gnt=%b m_en=%b m_we=%b m_addr=%h want 1 1 0 00000010",
                     f_gnt, m_en, m_we, m_addr);
        end
        adv();
        set_in(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (!(f_rvalid === 1'b1 && f_rdata === 32'h13 && d_rvalid === 1'b0)) begin
            errors++;
            $display("FAIL fetch_read rsp: got f_rvalid=%b f_rdata=%h want 1 00000013", f_rvalid, f_rdata);
        end
        checks++;
        if (obs !== exp_o) begin
            errors++;
            $display("FAIL fetch_read model: got %h want %h", obs, exp_o);
        end
        adv();
    endtask

    task automatic test_contention();
        logic [3:0] want_d;
        want_d = RR ? 4'b0101 : 4'b1111;
        set_in(0, 0, 0, 0, 0, 0, 0);
        adv();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 32'h100 + 32'(i * 4), 1, 0, 32'h200, 0);
            checks++;
            if (d_gnt !== want_d[i] || f_gnt !== !want_d[i]) begin
                errors++;
                $display("FAIL contention c%0d: got d_gnt=%b f_gnt=%b want d_gnt=%b", i, d_gnt, f_gnt, want_d[i]);
            end
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL contention model c%0d: got %h want %h", i, obs, exp_o);
            end
            adv();
        end
    endtask

    task automatic test_write_read();
        set_in(1, 0, 0, 1, 1, 32'h40, 32'hDEADBEEF);
        checks++;
        if (!(d_gnt === 1'b1 && m_en === 1'b1 && m_we === 1'b1 && m_addr === 32'h40 && m_wdata === 32'hDEADBEEF)) begin
            errors++;
            $display("FAIL write grant: got d_gnt=%b m_we=%b m_addr=%h m_wdata=%h", d_gnt, m_we, m_addr, m_wdata);
        end
        adv();
        set_in(1, 0, 0, 1, 0, 32'h40, 0);
        checks++;
        if (d_rvalid !== 1'b0 || d_gnt !== 1'b1 || m_we !== 1'b0) begin
            errors++;
            $display("FAIL write no_rsp: got d_rvalid=%b d_gnt=%b m_we=%b want 0 1 0", d_rvalid, d_gnt, m_we);
        end
        adv();
        set_in(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write readback: got d_rvalid=%b d_rdata=%h want 1 deadbeef", d_rvalid, d_rdata);
        end
        adv();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            set_in(1, i < 3, 32'(i * 4), 0, 0, 0, 0);
            checks++;
            if (f_gnt !== (i < 3) || f_rvalid !== (i > 0)) begin
                errors++;
                $display("FAIL back_to_back c%0d: got f_gnt=%b f_rvalid=%b", i, f_gnt, f_rvalid);
            end
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL back_to_back model c%0d: got %h want %h", i, obs, exp_o);
            end
            adv();
        end
    endtask

    task automatic test_reset_inflight();
        set_in(1, 0, 0, 1, 0, 32'h80, 0);
        adv();
        set_in(0, 1, 32'h4, 1, 0, 32'h8, 0);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_inflight: got %h want 0", obs);
        end
        adv();
        set_in(1, 1, 32'h4, 1, 0, 32'h8, 0);
        checks++;
        if (d_gnt !== 1'b1 || f_gnt !== 1'b0 || d_rvalid !== 1'b0 || f_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_inflight first: got d_gnt=%b f_gnt=%b rvalid=%b%b want 1 0 00",
                     d_gnt, f_gnt, f_rvalid, d_rvalid);
        end
        adv();
    endtask

    task automatic test_idle();
        set_in(1, 0, 0, 0, 0, 0, 0);
        adv();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, $urandom, 0, 1'($urandom), $urandom, $urandom);
            checks++;
            if ({m_en, m_we, f_gnt, d_gnt, f_rvalid, d_rvalid} !== 6'b0) begin
                errors++;
                $display("FAIL idle c%0d: got %b want 000000", i, {m_en, m_we, f_gnt, d_gnt, f_rvalid, d_rvalid});
            end
            adv();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 39) != 0, 1'($urandom), {26'b0, 4'($urandom), 2'b00},
                   1'($urandom), 1'($urandom), {26'b0, 4'($urandom), 2'b00}, $urandom);
            checks++;
            if (obs !== exp_o) begin
                errors++;
                $display("FAIL random c%0d: got %h want %h", i, obs, exp_o);
            end
            adv();
        end
    endtask

    initial begin
        rst_n = 1'b0; f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_fetch_read();
        test_contention();
        test_write_read();
        test_back_to_back();
        test_reset_inflight();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
